// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS fetch constants and PC increment helper
package mips_pkg;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] IRQ_PC    = 32'h8000_0004;
  localparam logic [31:0] EXC_PC    = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam int          KMODE_BIT = 31;

  // Sequential fetch advances only the low 31 bits; the kernel-mode bit rides along.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[KMODE_BIT], pc[KMODE_BIT-1:0] + 31'd4};
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch stage control, ROM bus and IF/ID bundle (perf outputs under IF_PERF_CNT_EN)
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        exc;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] epc;
  logic        trap_taken;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_bubble;

  modport master (
    input  stall, flush, redirect, redirect_pc, irq, exc, rom_data,
    output rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc, trap_taken,
    output perf_fetch, perf_bubble
  );
  modport slave (
    output stall, flush, redirect, redirect_pc, irq, exc, rom_data,
    input  rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc, trap_taken,
    input  perf_fetch, perf_bubble
  );
`else
  modport master (
    input  stall, flush, redirect, redirect_pc, irq, exc, rom_data,
    output rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc, trap_taken
  );
  modport slave (
    output stall, flush, redirect, redirect_pc, irq, exc, rom_data,
    input  rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc, trap_taken
  );
`endif
endinterface

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - combinational next-PC priority mux with trap/bubble/hold decisions
import mips_pkg::*;

module if_next_pc #(
  parameter logic [31:0] IRQ_PC = mips_pkg::IRQ_PC,
  parameter logic [31:0] EXC_PC = mips_pkg::EXC_PC
) (
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_irq,
  input  logic        i_exc,
  output logic [31:0] o_next_pc,
  output logic        o_trap,
  output logic        o_bubble,
  output logic        o_hold
);
  logic w_irq_taken;

  // Interrupts are masked in kernel mode and lose to a simultaneous exception.
  assign w_irq_taken = i_irq & ~i_pc[KMODE_BIT] & ~i_exc;
  assign o_trap      = i_exc | w_irq_taken;
  assign o_bubble    = i_flush | o_trap;
  assign o_hold      = i_stall & ~o_bubble;

  always_comb begin
    o_next_pc = pc_plus4(i_pc);
    if (i_exc)            o_next_pc = EXC_PC;
    else if (w_irq_taken) o_next_pc = IRQ_PC;
    else if (i_redirect)  o_next_pc = i_redirect_pc;
    else if (i_stall)     o_next_pc = i_pc;
  end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch stage: PC, IF/ID register, epc (perf counters under IF_PERF_CNT_EN)
import mips_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] IRQ_PC   = mips_pkg::IRQ_PC,
  parameter logic [31:0] EXC_PC   = mips_pkg::EXC_PC
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_if.master    bus
);
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_epc;
  logic        r_trap_taken;

  logic [31:0] w_next_pc;
  logic        w_trap;
  logic        w_bubble;
  logic        w_hold;

  if_next_pc #(
    .IRQ_PC (IRQ_PC),
    .EXC_PC (EXC_PC)
  ) u_next_pc (
    .i_pc          (r_pc),
    .i_stall       (bus.stall),
    .i_flush       (bus.flush),
    .i_redirect    (bus.redirect),
    .i_redirect_pc (bus.redirect_pc),
    .i_irq         (bus.irq),
    .i_exc         (bus.exc),
    .o_next_pc     (w_next_pc),
    .o_trap        (w_trap),
    .o_bubble      (w_bubble),
    .o_hold        (w_hold)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_instr      <= NOP_WORD;
      r_pc_plus4   <= 32'h0;
      r_valid      <= 1'b0;
      r_epc        <= 32'h0;
      r_trap_taken <= 1'b0;
    end else begin
      r_pc         <= w_next_pc;
      r_trap_taken <= w_trap;
      // A redirect resolving in the trap cycle is the instruction we must return to.
      if (w_trap) r_epc <= bus.redirect ? bus.redirect_pc : r_pc;
      if (w_bubble) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (!w_hold) begin
        r_instr    <= bus.rom_data;
        r_pc_plus4 <= pc_plus4(r_pc);
        r_valid    <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch  <= 32'h0;
      r_perf_bubble <= 32'h0;
    end else if (w_bubble || w_hold) begin
      r_perf_bubble <= r_perf_bubble + 32'd1;
    end else begin
      r_perf_fetch  <= r_perf_fetch + 32'd1;
    end
  end

  assign bus.perf_fetch  = r_perf_fetch;
  assign bus.perf_bubble = r_perf_bubble;
`endif

  assign bus.rom_addr       = r_pc[30:0];
  assign bus.pc             = r_pc;
  assign bus.if_id_instr    = r_instr;
  assign bus.if_id_pc_plus4 = r_pc_plus4;
  assign bus.if_id_valid    = r_valid;
  assign bus.epc            = r_epc;
  assign bus.trap_taken     = r_trap_taken;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a spec-level reference model
module tb_if_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] rom [0:63];

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM covers byte addresses 0..255; anything else reads as a nop.
  assign bus.rom_data = (bus.rom_addr[30:8] == 23'h0) ? rom[bus.rom_addr[7:2]] : 32'h0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_trap;
  longint      m_fetch, m_bubble;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] off;
    off = a & 32'h7FFF_FFFF;
    if (off < 32'd256) return rom[off[7:2]];
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] seq;
    logic        take_irq, trap, bub, hold;
    if (rst) begin
      m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_trap = 0;
      m_fetch = 0; m_bubble = 0;
      return;
    end
    seq      = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    take_irq = bus.irq && (m_pc < 32'h8000_0000) && !bus.exc;
    trap     = bus.exc || take_irq;
    bub      = trap || bus.flush;
    hold     = bus.stall && !bub;
    if (trap) m_epc = bus.redirect ? bus.redirect_pc : m_pc;
    if (bub) begin
      m_instr = 0; m_valid = 0; m_bubble++;
    end else if (hold) begin
      m_bubble++;
    end else begin
      m_instr = rom_word(m_pc); m_pc4 = seq; m_valid = 1; m_fetch++;
    end
    m_trap = trap;
    if (bus.exc)           m_pc = 32'h8000_0008;
    else if (take_irq)     m_pc = 32'h8000_0004;
    else if (bus.redirect) m_pc = bus.redirect_pc;
    else if (!bus.stall)   m_pc = seq;
  endtask

  task automatic compare_all();
    check_eq("pc", bus.pc, m_pc);
    check_eq("rom_addr", {1'b0, bus.rom_addr}, m_pc & 32'h7FFF_FFFF);
    check_eq("valid", {31'h0, bus.if_id_valid}, {31'h0, m_valid});
    check_eq("instr", bus.if_id_instr, m_instr);
    if (m_valid) check_eq("pc_plus4", bus.if_id_pc_plus4, m_pc4);
    check_eq("epc", bus.epc, m_epc);
    check_eq("trap_taken", {31'h0, bus.trap_taken}, {31'h0, m_trap});
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch", bus.perf_fetch, m_fetch[31:0]);
    check_eq("perf_bubble", bus.perf_bubble, m_bubble[31:0]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; bus.stall = 0; bus.flush = 0; bus.redirect = 0;
    bus.redirect_pc = 0; bus.irq = 0; bus.exc = 0;
  endtask

  task automatic jump(input logic [31:0] target);
    idle(); bus.redirect = 1; bus.redirect_pc = target;
    step();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h0800_0003;
    idle();
    rst = 1;
    step(); step();
    check_eq("reset_pc", bus.pc, 32'h8000_0000);
    check_eq("reset_valid", {31'h0, bus.if_id_valid}, 32'h0);

    // 1: first fetch after reset
    rst = 0;
    step();
    check_eq("s1_instr", bus.if_id_instr, 32'h0800_0003);
    check_eq("s1_pc", bus.pc, 32'h8000_0004);

    // 2: stall three cycles at 8000_0010
    for (int k = 0; k < 8 && m_pc != 32'h8000_0010; k++) step();
    check_eq("s2_reach", bus.pc, 32'h8000_0010);
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("s2_hold_pc", bus.pc, 32'h8000_0010);
      check_eq("s2_hold_instr", bus.if_id_instr, rom[3]);
    end
    bus.stall = 0;
    step();
    check_eq("s2_release", bus.pc, 32'h8000_0014);

    // 3: redirect + flush + stall together
    bus.redirect = 1; bus.redirect_pc = 32'h8000_0088; bus.flush = 1; bus.stall = 1;
    step();
    idle();
    check_eq("s3_pc", bus.pc, 32'h8000_0088);
    check_eq("s3_valid", {31'h0, bus.if_id_valid}, 32'h0);

    // 4: interrupt in user mode, then masked in kernel mode
    jump(32'h0000_0040);
    bus.irq = 1;
    step();
    check_eq("s4_pc", bus.pc, 32'h8000_0004);
    check_eq("s4_epc", bus.epc, 32'h0000_0040);
    check_eq("s4_trap", {31'h0, bus.trap_taken}, 32'h1);
    check_eq("s4_valid", {31'h0, bus.if_id_valid}, 32'h0);
    step();
    check_eq("s4_pulse", {31'h0, bus.trap_taken}, 32'h0);
    jump(32'h8000_0040);
    bus.irq = 1;
    step();
    check_eq("s4_masked", bus.pc, 32'h8000_0044);
    idle();

    // 5: exception wins over irq; epc takes the concurrent redirect target
    jump(32'h0000_0020);
    bus.exc = 1; bus.irq = 1; bus.redirect = 1; bus.redirect_pc = 32'h0000_0100;
    step();
    idle();
    check_eq("s5_pc", bus.pc, 32'h8000_0008);
    check_eq("s5_epc", bus.epc, 32'h0000_0100);
`ifdef IF_PERF_CNT_EN
    check_eq("s5_perf_sum", bus.perf_fetch + bus.perf_bubble, 32'(m_fetch + m_bubble));
`endif

    // 6: user-mode wrap keeps bit 31 clear
    jump(32'h7FFF_FFFC);
    step();
    check_eq("s6_wrap", bus.pc, 32'h0000_0000);

    // Reset during a would-be trap: no pulse
    jump(32'h0000_0010);
    rst = 1; bus.irq = 1;
    step();
    check_eq("rst_trap_pc", bus.pc, 32'h8000_0000);
    check_eq("rst_trap_pulse", {31'h0, bus.trap_taken}, 32'h0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rst             = ($urandom_range(0, 99) < 2);
      bus.stall       = ($urandom_range(0, 99) < 25);
      bus.flush       = ($urandom_range(0, 99) < 12);
      bus.redirect    = ($urandom_range(0, 99) < 15);
      bus.redirect_pc = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 80) * 4)};
      if ($urandom_range(0, 99) < 3) bus.redirect_pc = 32'h7FFF_FFF8;
      bus.irq         = ($urandom_range(0, 99) < 15);
      bus.exc         = ($urandom_range(0, 99) < 5);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
